// File: rtl/datamem_pkg.sv
// -----------------------------------------------------------------------------
// datamem_pkg
// Shared definitions for the word-organised data memory of the single-cycle
// CPU datapath (MEM stage).
//   DATA_W        : datapath word width (fixed at 32)
//   DEFAULT_DEPTH : default number of words
//   word_t        : one memory word
//   word_index()  : byte address -> word index (drops the byte offset and
//                   wraps modulo the depth)
// Optional feature (handled in data_memory): DATAMEM_BOUNDS_CHECK_EN
// -----------------------------------------------------------------------------
package datamem_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEFAULT_DEPTH = 256;

  typedef logic [31:0] word_t;

  // Byte address to word index. Bits [1:0] are the byte offset inside a word.
  // depth is a power of two, so masking with depth-1 wraps the index.
  function automatic int unsigned word_index(input logic [31:0] addr,
                                             input int unsigned depth);
    logic [31:0] mask;
    mask = depth - 32'd1;
    return int'((addr >> 2) & mask);
  endfunction

endpackage : datamem_pkg

// File: rtl/datamem_array.sv
// -----------------------------------------------------------------------------
// datamem_array
// Register array with asynchronous clear, synchronous clear, one synchronous
// write port and one combinational read port.
// Ports:
//   clk      in  clock, state changes on the rising edge
//   rst_n    in  asynchronous active-low reset, clears every word
//   clr_i    in  synchronous clear of every word
//   we_i     in  write enable (wins over clr_i for the addressed word)
//   waddr_i  in  write word index
//   wdata_i  in  write data
//   raddr_i  in  read word index
//   rdata_o  out read data (combinational, no write bypass)
// -----------------------------------------------------------------------------
module datamem_array
  import datamem_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [31:0]       rdata_o
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];

  // Next-state of every word: addressed write first, then clear, else hold.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (we_i && (waddr_i == IDX_W'(i))) begin
        mem_d[i] = wdata_i;
      end else if (clr_i) begin
        mem_d[i] = 32'h0000_0000;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Storage; reset clears asynchronously and blocks any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read port: shows the stored value, never the incoming write.
  assign rdata_o = mem_q[raddr_i];

endmodule : datamem_array

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
// 32-bit word-organised data memory for the MEM stage. Synchronous writes,
// combinational reads, Startin strobe clears the contents.
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset (all words read as 0)
//   Address    in  byte address from the ALU; word index is
//                  Address[$clog2(DEPTH)+1:2]
//   WriteData  in  store data
//   MemWrite   in  write enable, sampled on the rising edge
//   MemRead    in  read enable, gates ReadData (0 when low)
//   Startin    in  synchronous clear strobe; a same-edge write still lands
//   ReadData   out read data to the write-back mux (combinational)
// Configuration macro:
//   DATAMEM_BOUNDS_CHECK_EN - when defined, addresses with any bit set above
//   the index field are out of range: writes are dropped and reads return 0.
//   When undefined, those bits are ignored and the address space wraps.
// -----------------------------------------------------------------------------
module data_memory
  import datamem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned DATA_W = datamem_pkg::DATA_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        Startin,
  output logic [31:0] ReadData
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx_s;
  logic             in_range_s;
  logic             we_s;
  logic [31:0]      arr_rdata_s;
  logic             unused_cfg_s;

  // DATA_W is fixed by the datapath; it only documents the word width here.
  assign unused_cfg_s = (DATA_W == 32'd32);

  // Word index: byte offset dropped, upper bits wrap.
  assign idx_s = IDX_W'(word_index(Address, DEPTH));

`ifdef DATAMEM_BOUNDS_CHECK_EN
  // Out of range when any address bit above the index field is set.
  assign in_range_s = ~|Address[31:IDX_W+2];
`else
  // Upper bits are ignored: every address aliases onto some word.
  assign in_range_s = 1'b1;
`endif

  assign we_s = MemWrite & in_range_s;

  datamem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (Startin),
    .we_i    (we_s),
    .waddr_i (idx_s),
    .wdata_i (WriteData),
    .raddr_i (idx_s),
    .rdata_o (arr_rdata_s)
  );

  // Read gating: MemRead low or out-of-range access returns zero.
  always_comb begin
    if (MemRead && in_range_s) begin
      ReadData = arr_rdata_s;
    end else begin
      ReadData = 32'h0000_0000;
    end
  end

endmodule : data_memory

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
// Directed test-plan steps followed by randomized accesses, all checked
// against a behavioural model of the memory (plain array + arithmetic).
// -----------------------------------------------------------------------------
module tb_data_memory;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst_n;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic        Startin;
  logic [31:0] ReadData;

  int vectors;
  int miscompares;

  logic [31:0] ref_mem [DEPTH];

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Address   (Address),
    .WriteData (WriteData),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Startin   (Startin),
    .ReadData  (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address is in range when it lies inside the first DEPTH*4 bytes.
  function automatic bit model_in_range(input logic [31:0] a);
`ifdef DATAMEM_BOUNDS_CHECK_EN
    return (a < DEPTH * 4);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
    if (rd && model_in_range(a)) return ref_mem[model_idx(a)];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; the model applies the same edge with the current inputs.
  task automatic tick();
    if (rst_n) begin
      if (Startin) model_clear();
      if (MemWrite && model_in_range(Address)) ref_mem[model_idx(Address)] = WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1; Startin = 1'b0;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic read_at(input logic [31:0] a, input logic rd);
    Address = a; MemRead = rd;
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    vectors = 0;
    miscompares = 0;
    model_clear();
    rst_n = 1'b0; Address = 32'h0; WriteData = 32'h0;
    MemWrite = 1'b0; MemRead = 1'b1; Startin = 1'b0;

    // Reset state
    #2;
    check("reset_read0", ReadData, 32'h0);
    read_at(32'h0000_0010, 1'b1);
    check("reset_read10", ReadData, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write during Startin: the write wins
    Address = 32'h4; WriteData = 32'hAAAA_AAAA; MemWrite = 1'b1; Startin = 1'b1;
    tick();
    Startin = 1'b0; MemWrite = 1'b0;
    read_at(32'h4, 1'b1);
    check("start_write_wins", ReadData, 32'hAAAA_AAAA);

    // Startin clears
    write_word(32'h8, 32'h1234_5678);
    read_at(32'h8, 1'b1);
    check("pre_clear", ReadData, 32'h1234_5678);
    Startin = 1'b1;
    tick();
    Startin = 1'b0;
    read_at(32'h8, 1'b1);
    check("startin_clears", ReadData, 32'h0);
    read_at(32'h4, 1'b1);
    check("startin_clears_4", ReadData, 32'h0);

    // Read gating and misalignment
    write_word(32'h10, 32'hDEAD_BEEF);
    read_at(32'h10, 1'b0);
    check("memread_gate", ReadData, 32'h0);
    read_at(32'h13, 1'b1);
    check("misaligned", ReadData, 32'hDEAD_BEEF);

    // Async reset between edges, with a write pending across the reset
    write_word(32'h0, 32'hCAFE_F00D);
    read_at(32'h0, 1'b1);
    check("pre_reset", ReadData, 32'hCAFE_F00D);
    #2;
    rst_n = 1'b0;
    WriteData = 32'h5555_5555; MemWrite = 1'b1;
    #1;
    check("async_reset_now", ReadData, 32'h0);
    model_clear();
    @(posedge clk); #3;
    MemWrite = 1'b0;
    rst_n = 1'b1;
    #1;
    check("after_release", ReadData, 32'h0);
    @(posedge clk); #1;
    check("after_release_edge", ReadData, 32'h0);

    // Wrap / bounds check
    write_word(32'h0, 32'h7777_0000);
    write_word(32'h400, 32'h1111_1111);
    read_at(32'h0, 1'b1);
`ifdef DATAMEM_BOUNDS_CHECK_EN
    check("bounds_low_kept", ReadData, 32'h7777_0000);
    read_at(32'h400, 1'b1);
    check("bounds_high_zero", ReadData, 32'h0);
`else
    check("wrap_alias", ReadData, 32'h1111_1111);
    read_at(32'h400, 1'b1);
    check("wrap_alias_hi", ReadData, 32'h1111_1111);
`endif

    // Same-word read during write: old before the edge, new after it
    write_word(32'h20, 32'h1);
    Address = 32'h20; WriteData = 32'h2; MemWrite = 1'b1; MemRead = 1'b1;
    #1;
    check("rdw_old", ReadData, 32'h1);
    tick();
    MemWrite = 1'b0;
    check("rdw_new", ReadData, 32'h2);

    // Randomized accesses against the model
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0, 1:    a = a & 32'h0000_03FF;
        2:       a = a & 32'h0000_0FFF;
        default: a = a;
      endcase
      d = $urandom;
      Address = a; WriteData = d;
      MemWrite = ($urandom_range(0, 1) == 1);
      MemRead  = ($urandom_range(0, 3) != 0);
      Startin  = ($urandom_range(0, 40) == 0);
      #1;
      check("rand_pre", ReadData, model_read(a, MemRead));
      tick();
      check("rand_post", ReadData, model_read(a, MemRead));
      Startin = 1'b0;
    end

    // Sweep a few words after the random phase
    MemWrite = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      read_at(a, 1'b1);
      check("sweep", ReadData, model_read(a, 1'b1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_data_memory
